// File: rtl/decode_stage_if.sv
// decode_stage_if: bundles the decode stage's pipeline-facing signals.
//   slave  : view taken by decode_stage (fetch/control/regfile/forward in, E register out)
//   master : view taken by the surrounding pipeline or a testbench
//   Groups : f_* (F->D inputs), D_stall/D_bubble/E_bubble (control),
//            srcA/srcB/rvalA/rvalB (register file), *_dst*/*_val* (forwarding),
//            E_* (D->E register), d_srcA/d_srcB (hazard unit copies)
interface decode_stage_if #(parameter int W = 64);
    logic [2:0]   f_stat;
    logic [3:0]   f_icode, f_ifun, f_rA, f_rB;
    logic [W-1:0] f_valC, f_valP;
    logic         D_stall, D_bubble, E_bubble;
    logic [3:0]   srcA, srcB, d_srcA, d_srcB;
    logic [W-1:0] rvalA, rvalB;
    logic [3:0]   e_dstE, M_dstM, M_dstE, W_dstM, W_dstE;
    logic [W-1:0] e_valE, m_valM, M_valE, W_valM, W_valE;
    logic [2:0]   E_stat;
    logic [3:0]   E_icode, E_ifun;
    logic [W-1:0] E_valC, E_valA, E_valB;
    logic [3:0]   E_dstE, E_dstM, E_srcA, E_srcB;

    modport slave (
        input  f_stat, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP,
        input  D_stall, D_bubble, E_bubble,
        input  rvalA, rvalB,
        input  e_dstE, M_dstM, M_dstE, W_dstM, W_dstE,
        input  e_valE, m_valM, M_valE, W_valM, W_valE,
        output srcA, srcB, d_srcA, d_srcB,
        output E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB,
        output E_dstE, E_dstM, E_srcA, E_srcB
    );

    modport master (
        output f_stat, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP,
        output D_stall, D_bubble, E_bubble,
        output rvalA, rvalB,
        output e_dstE, M_dstM, M_dstE, W_dstM, W_dstE,
        output e_valE, m_valM, M_valE, W_valM, W_valE,
        input  srcA, srcB, d_srcA, d_srcB,
        input  E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB,
        input  E_dstE, E_dstM, E_srcA, E_srcB
    );
endinterface

// File: rtl/decode_stage.sv
// decode_stage: Y86-64 decode stage. Holds the F->D register, derives
// srcA/srcB/dstE/dstM, selects valA/valB (valP, forwarding, or register
// file) and loads the D->E register.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset, loads both registers with bubbles
//   dif   : decode_stage_if slave port (see interface header for groups)
module decode_stage #(
    parameter int W = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    decode_stage_if.slave  dif
);
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] RSP      = 4'h4;
    localparam logic [3:0] RNONE    = 4'hF;
    localparam logic [2:0] S_AOK    = 3'd1;

    logic [2:0]   r_d_stat;
    logic [3:0]   r_d_icode, r_d_ifun, r_d_ra, r_d_rb;
    logic [W-1:0] r_d_valc, r_d_valp;

    logic [3:0]   w_src_a, w_src_b, w_dst_e, w_dst_m;
    logic [W-1:0] w_val_a, w_val_b;

    logic [2:0]   r_e_stat;
    logic [3:0]   r_e_icode, r_e_ifun, r_e_dst_e, r_e_dst_m, r_e_src_a, r_e_src_b;
    logic [W-1:0] r_e_valc, r_e_vala, r_e_valb;

    // F->D register; stall has priority over bubble
    always_ff @(posedge clk) begin
        if (!rst_n || (!dif.D_stall && dif.D_bubble)) begin
            r_d_stat  <= S_AOK;
            r_d_icode <= I_NOP;
            r_d_ifun  <= 4'h0;
            r_d_ra    <= RNONE;
            r_d_rb    <= RNONE;
            r_d_valc  <= '0;
            r_d_valp  <= '0;
        end else if (!dif.D_stall) begin
            r_d_stat  <= dif.f_stat;
            r_d_icode <= dif.f_icode;
            r_d_ifun  <= dif.f_ifun;
            r_d_ra    <= dif.f_rA;
            r_d_rb    <= dif.f_rB;
            r_d_valc  <= dif.f_valC;
            r_d_valp  <= dif.f_valP;
        end
    end

    always_comb begin
        w_src_a = RNONE;
        w_src_b = RNONE;
        w_dst_e = RNONE;
        w_dst_m = RNONE;
        case (r_d_icode)
            I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: w_src_a = r_d_ra;
            I_RET, I_POPQ:                      w_src_a = RSP;
            default: ;
        endcase
        case (r_d_icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ:          w_src_b = r_d_rb;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:     w_src_b = RSP;
            default: ;
        endcase
        // CMOV still writes rB here; execute squashes it when the condition fails
        case (r_d_icode)
            I_RRMOVQ, I_IRMOVQ, I_OPQ:          w_dst_e = r_d_rb;
            I_CALL, I_RET, I_PUSHQ, I_POPQ:     w_dst_e = RSP;
            default: ;
        endcase
        case (r_d_icode)
            I_MRMOVQ, I_POPQ:                   w_dst_m = r_d_ra;
            default: ;
        endcase
    end

    // Forwarding: youngest producer first; RNONE never matches
    always_comb begin
        w_val_a = dif.rvalA;
        if (r_d_icode == I_CALL || r_d_icode == I_JXX)        w_val_a = r_d_valp;
        else if (w_src_a != RNONE && w_src_a == dif.e_dstE)    w_val_a = dif.e_valE;
        else if (w_src_a != RNONE && w_src_a == dif.M_dstM)    w_val_a = dif.m_valM;
        else if (w_src_a != RNONE && w_src_a == dif.M_dstE)    w_val_a = dif.M_valE;
        else if (w_src_a != RNONE && w_src_a == dif.W_dstM)    w_val_a = dif.W_valM;
        else if (w_src_a != RNONE && w_src_a == dif.W_dstE)    w_val_a = dif.W_valE;
    end

    always_comb begin
        w_val_b = dif.rvalB;
        if (w_src_b != RNONE && w_src_b == dif.e_dstE)         w_val_b = dif.e_valE;
        else if (w_src_b != RNONE && w_src_b == dif.M_dstM)    w_val_b = dif.m_valM;
        else if (w_src_b != RNONE && w_src_b == dif.M_dstE)    w_val_b = dif.M_valE;
        else if (w_src_b != RNONE && w_src_b == dif.W_dstM)    w_val_b = dif.W_valM;
        else if (w_src_b != RNONE && w_src_b == dif.W_dstE)    w_val_b = dif.W_valE;
    end

    // D->E register; a stalled D simply re-issues its decode here
    always_ff @(posedge clk) begin
        if (!rst_n || dif.E_bubble) begin
            r_e_stat  <= S_AOK;
            r_e_icode <= I_NOP;
            r_e_ifun  <= 4'h0;
            r_e_valc  <= '0;
            r_e_vala  <= '0;
            r_e_valb  <= '0;
            r_e_dst_e <= RNONE;
            r_e_dst_m <= RNONE;
            r_e_src_a <= RNONE;
            r_e_src_b <= RNONE;
        end else begin
            r_e_stat  <= r_d_stat;
            r_e_icode <= r_d_icode;
            r_e_ifun  <= r_d_ifun;
            r_e_valc  <= r_d_valc;
            r_e_vala  <= w_val_a;
            r_e_valb  <= w_val_b;
            r_e_dst_e <= w_dst_e;
            r_e_dst_m <= w_dst_m;
            r_e_src_a <= w_src_a;
            r_e_src_b <= w_src_b;
        end
    end

    assign dif.srcA    = w_src_a;
    assign dif.srcB    = w_src_b;
    assign dif.d_srcA  = w_src_a;
    assign dif.d_srcB  = w_src_b;
    assign dif.E_stat  = r_e_stat;
    assign dif.E_icode = r_e_icode;
    assign dif.E_ifun  = r_e_ifun;
    assign dif.E_valC  = r_e_valc;
    assign dif.E_valA  = r_e_vala;
    assign dif.E_valB  = r_e_valb;
    assign dif.E_dstE  = r_e_dst_e;
    assign dif.E_dstM  = r_e_dst_m;
    assign dif.E_srcA  = r_e_src_a;
    assign dif.E_srcB  = r_e_src_b;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: scoreboard bench for decode_stage. Expected D->E contents
// are queued when an instruction is driven and compared after its E edge.
module tb_decode_stage;
    localparam logic [3:0] F = 4'hF;

    typedef struct {
        logic [2:0]  stat;
        logic [3:0]  icode, ifun;
        logic [63:0] valC, valA, valB;
        logic [3:0]  dstE, dstM, srcA, srcB;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [63:0] regs [16];
    exp_t exp_q [$];
    int n_tests = 0;
    int n_fail  = 0;

    decode_stage_if #(.W(64)) dif ();
    decode_stage #(.W(64)) dut (.clk(clk), .rst_n(rst_n), .dif(dif));

    always #5 clk = ~clk;

    // register file model: reads return 0 for RNONE
    assign dif.rvalA = (dif.srcA == F) ? 64'd0 : regs[dif.srcA];
    assign dif.rvalB = (dif.srcB == F) ? 64'd0 : regs[dif.srcB];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] st, input logic [3:0] ic, fn,
                                input logic [63:0] vc, va, vb,
                                input logic [3:0] de, dm, sa, sb);
        exp_t e;
        e.stat = st; e.icode = ic; e.ifun = fn; e.valC = vc; e.valA = va; e.valB = vb;
        e.dstE = de; e.dstM = dm; e.srcA = sa; e.srcB = sb;
        return e;
    endfunction

    task automatic pop_check(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check({tag, ".sb_empty"}, 64'd0, 64'd1);
            return;
        end
        e = exp_q.pop_front();
        check({tag, ".stat"},  64'(dif.E_stat),  64'(e.stat));
        check({tag, ".icode"}, 64'(dif.E_icode), 64'(e.icode));
        check({tag, ".ifun"},  64'(dif.E_ifun),  64'(e.ifun));
        check({tag, ".valC"},  dif.E_valC,       e.valC);
        check({tag, ".valA"},  dif.E_valA,       e.valA);
        check({tag, ".valB"},  dif.E_valB,       e.valB);
        check({tag, ".dstE"},  64'(dif.E_dstE),  64'(e.dstE));
        check({tag, ".dstM"},  64'(dif.E_dstM),  64'(e.dstM));
        check({tag, ".srcA"},  64'(dif.E_srcA),  64'(e.srcA));
        check({tag, ".srcB"},  64'(dif.E_srcB),  64'(e.srcB));
    endtask

    task automatic drive_f(input logic [2:0] st, input logic [3:0] ic, fn, ra, rb,
                           input logic [63:0] vc, vp);
        dif.f_stat = st; dif.f_icode = ic; dif.f_ifun = fn;
        dif.f_rA = ra; dif.f_rB = rb; dif.f_valC = vc; dif.f_valP = vp;
    endtask

    // distinct non-zero junk so an unguarded RNONE match shows up
    task automatic clr_fwd();
        dif.e_dstE = F; dif.M_dstM = F; dif.M_dstE = F; dif.W_dstM = F; dif.W_dstE = F;
        dif.e_valE = 64'hDEAD_0001; dif.m_valM = 64'hDEAD_0002; dif.M_valE = 64'hDEAD_0003;
        dif.W_valM = 64'hDEAD_0004; dif.W_valE = 64'hDEAD_0005;
    endtask

    task automatic issue(input string tag, input logic [2:0] st, input logic [3:0] ic, fn, ra, rb,
                         input logic [63:0] vc, vp, input logic [3:0] xsa, xsb, input exp_t e);
        drive_f(st, ic, fn, ra, rb, vc, vp);
        @(posedge clk); #1;
        check({tag, ".d_srcA"}, 64'(dif.srcA),   64'(xsa));
        check({tag, ".d_srcB"}, 64'(dif.srcB),   64'(xsb));
        check({tag, ".hz_srcA"}, 64'(dif.d_srcA), 64'(xsa));
        check({tag, ".hz_srcB"}, 64'(dif.d_srcB), 64'(xsb));
        exp_q.push_back(e);
        @(posedge clk); #1;
        pop_check(tag);
    endtask

    exp_t bub, opq_e;

    initial begin
        for (int i = 0; i < 16; i++) regs[i] = 64'hA0 + 64'(i);
        regs[2] = 64'd5;
        regs[3] = 64'd7;
        bub = mk(3'd1, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, F, F, F, F);
        clr_fwd();
        dif.D_bubble = 1'b0; dif.E_bubble = 1'b0;

        // reset overrides stall
        rst_n = 1'b0; dif.D_stall = 1'b1;
        drive_f(3'd1, 4'h6, 4'h0, 4'h2, 4'h3, 64'h12, 64'h34);
        exp_q.push_back(bub);
        repeat (2) @(posedge clk);
        #1;
        pop_check("reset");
        check("reset.srcA", 64'(dif.srcA), 64'(F));
        check("reset.srcB", 64'(dif.srcB), 64'(F));
        rst_n = 1'b1; dif.D_stall = 1'b0;

        issue("opq", 3'd1, 4'h6, 4'h0, 4'h2, 4'h3, 64'd0, 64'h20, 4'h2, 4'h3,
              mk(3'd1, 4'h6, 4'h0, 64'd0, 64'd5, 64'd7, 4'h3, F, 4'h2, 4'h3));

        // forwarding priority on srcA
        dif.e_dstE = 4'h2; dif.e_valE = 64'h11;
        dif.M_dstE = 4'h2; dif.M_valE = 64'h22;
        dif.W_dstM = 4'h2; dif.W_valM = 64'h33;
        issue("fwd_e", 3'd1, 4'h6, 4'h1, 4'h2, 4'h3, 64'd0, 64'h20, 4'h2, 4'h3,
              mk(3'd1, 4'h6, 4'h1, 64'd0, 64'h11, 64'd7, 4'h3, F, 4'h2, 4'h3));
        dif.e_dstE = F;
        issue("fwd_mE", 3'd1, 4'h6, 4'h1, 4'h2, 4'h3, 64'd0, 64'h20, 4'h2, 4'h3,
              mk(3'd1, 4'h6, 4'h1, 64'd0, 64'h22, 64'd7, 4'h3, F, 4'h2, 4'h3));
        clr_fwd();
        issue("irmov_nofwd", 3'd1, 4'h3, 4'h0, F, 4'h2, 64'hFEDC_BA98_7654_3210, 64'h2A, F, F,
              mk(3'd1, 4'h3, 4'h0, 64'hFEDC_BA98_7654_3210, 64'd0, 64'd0, 4'h2, F, F, F));

        // m_valM beats M_valE; W_valE is the last resort
        dif.M_dstM = 4'h3; dif.m_valM = 64'h44;
        dif.M_dstE = 4'h3; dif.M_valE = 64'h22;
        dif.W_dstE = 4'h5; dif.W_valE = 64'h8000_0000_0000_0066;
        issue("fwd_mM_wE", 3'd1, 4'h6, 4'h2, 4'h5, 4'h3, 64'd0, 64'h20, 4'h5, 4'h3,
              mk(3'd1, 4'h6, 4'h2, 64'd0, 64'h8000_0000_0000_0066, 64'h44, 4'h3, F, 4'h5, 4'h3));
        clr_fwd();

        dif.e_dstE = 4'h4; dif.e_valE = 64'h11;
        issue("call", 3'd1, 4'h8, 4'h0, F, F, 64'h400, 64'h100, F, 4'h4,
              mk(3'd1, 4'h8, 4'h0, 64'h400, 64'h100, 64'h11, 4'h4, F, F, 4'h4));
        clr_fwd();
        issue("jxx", 3'd1, 4'h7, 4'h3, F, F, 64'h88, 64'h209, F, F,
              mk(3'd1, 4'h7, 4'h3, 64'h88, 64'h209, 64'd0, F, F, F, F));
        issue("popq", 3'd1, 4'hB, 4'h0, 4'h6, F, 64'd0, 64'h2, 4'h4, 4'h4,
              mk(3'd1, 4'hB, 4'h0, 64'd0, 64'hA4, 64'hA4, 4'h4, 4'h6, 4'h4, 4'h4));
        issue("ret", 3'd1, 4'h9, 4'h0, F, F, 64'd0, 64'h1, 4'h4, 4'h4,
              mk(3'd1, 4'h9, 4'h0, 64'd0, 64'hA4, 64'hA4, 4'h4, F, 4'h4, 4'h4));
        issue("pushq", 3'd1, 4'hA, 4'h0, 4'h1, F, 64'd0, 64'h2, 4'h1, 4'h4,
              mk(3'd1, 4'hA, 4'h0, 64'd0, 64'hA1, 64'hA4, 4'h4, F, 4'h1, 4'h4));
        issue("rmmov", 3'd1, 4'h4, 4'h0, 4'h2, 4'h3, 64'h10, 64'hA, 4'h2, 4'h3,
              mk(3'd1, 4'h4, 4'h0, 64'h10, 64'd5, 64'd7, F, F, 4'h2, 4'h3));
        issue("cmov", 3'd1, 4'h2, 4'h3, 4'h1, 4'h7, 64'd0, 64'h2, 4'h1, F,
              mk(3'd1, 4'h2, 4'h3, 64'd0, 64'hA1, 64'd0, 4'h7, F, 4'h1, F));
        issue("mrmov", 3'd1, 4'h5, 4'h0, 4'h1, 4'h5, 64'h8, 64'hA, F, 4'h5,
              mk(3'd1, 4'h5, 4'h0, 64'h8, 64'd0, 64'hA5, F, 4'h1, F, 4'h5));
        issue("halt", 3'd2, 4'h0, 4'h0, 4'h1, 4'h2, 64'd0, 64'h1, F, F,
              mk(3'd2, 4'h0, 4'h0, 64'd0, 64'd0, 64'd0, F, F, F, F));
        issue("invalid", 3'd4, 4'hC, 4'h5, 4'h1, 4'h2, 64'h99, 64'h1, F, F,
              mk(3'd4, 4'hC, 4'h5, 64'h99, 64'd0, 64'd0, F, F, F, F));

        // stall / bubble interplay
        drive_f(3'd1, 4'h6, 4'h0, 4'h2, 4'h3, 64'h77, 64'h20);
        @(posedge clk); #1;
        opq_e = mk(3'd1, 4'h6, 4'h0, 64'h77, 64'd5, 64'd7, 4'h3, F, 4'h2, 4'h3);
        dif.D_stall = 1'b1;
        drive_f(3'd1, 4'h5, 4'h0, 4'h1, 4'h5, 64'h8, 64'hA);
        exp_q.push_back(opq_e);
        @(posedge clk); #1;
        pop_check("stall1");
        check("stall1.srcA", 64'(dif.srcA), 64'h2);
        check("stall1.srcB", 64'(dif.srcB), 64'h3);
        drive_f(3'd1, 4'hA, 4'h0, 4'h1, F, 64'd0, 64'h2);
        exp_q.push_back(opq_e);
        @(posedge clk); #1;
        pop_check("stall2");
        check("stall2.srcA", 64'(dif.srcA), 64'h2);
        check("stall2.srcB", 64'(dif.srcB), 64'h3);
        dif.D_bubble = 1'b1;
        exp_q.push_back(opq_e);
        @(posedge clk); #1;
        pop_check("stall_bub");
        check("stall_bub.srcA", 64'(dif.srcA), 64'h2);
        dif.D_bubble = 1'b0; dif.E_bubble = 1'b1;
        exp_q.push_back(bub);
        @(posedge clk); #1;
        pop_check("ebub");
        dif.E_bubble = 1'b0; dif.D_stall = 1'b0; dif.D_bubble = 1'b1;
        exp_q.push_back(opq_e);
        @(posedge clk); #1;
        pop_check("dbub_e");
        check("dbub.srcA", 64'(dif.srcA), 64'(F));
        check("dbub.srcB", 64'(dif.srcB), 64'(F));
        dif.D_bubble = 1'b0;
        drive_f(3'd1, 4'h1, 4'h0, F, F, 64'd0, 64'd0);
        exp_q.push_back(bub);
        @(posedge clk); #1;
        pop_check("dbub_nop");

        check("sb_drained", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/decode_stage.md
# decode_stage

Decode stage of the pipelined Y86-64 core, built around the existing register file. Holds the F→D pipeline register and generates `srcA`/`srcB` (to the register file), `dstE`/`dstM`. Selects `valA`/`valB` from register-file reads, `valP`, or forwarded execute/memory/write-back results. Loads the D→E pipeline register; the execute stage consumes its outputs.

## Interface
- `W`, 64: datapath width (`valC`, `valP`, all vals).
- `clk` input 1: single clock; all state updates on rising edge.
- `rst_n` input 1: reset, synchronous and active-low.
- `f_stat[2:0]`, `f_icode[3:0]`, `f_ifun[3:0]`, `f_rA[3:0]`, `f_rB[3:0]`, `f_valC[W-1:0]`, `f_valP[W-1:0]` inputs: fetch outputs into the D register.
- `D_stall`, `D_bubble`, `E_bubble` inputs 1: pipeline control.
- `srcA[3:0]`, `srcB[3:0]` outputs: register-file read addresses (combinational from the D register).
- `rvalA[W-1:0]`, `rvalB[W-1:0]` inputs: register-file read data; `0` when the address is `4'hF`.
- `e_dstE[3:0]`/`e_valE`, `M_dstM[3:0]`/`m_valM`, `M_dstE[3:0]`/`M_valE`, `W_dstM[3:0]`/`W_valM`, `W_dstE[3:0]`/`W_valE` inputs: forwarding sources.
- `E_stat[2:0]`, `E_icode[3:0]`, `E_ifun[3:0]`, `E_valC`, `E_valA`, `E_valB`, `E_dstE[3:0]`, `E_dstM[3:0]`, `E_srcA[3:0]`, `E_srcB[3:0]` outputs: D→E register contents.
- `d_srcA[3:0]`, `d_srcB[3:0]` outputs: copies of `srcA`/`srcB` for the hazard unit.

## Operation
- Icodes: HALT 0, NOP 1, RRMOVQ/CMOV 2, IRMOVQ 3, RMMOVQ 4, MRMOVQ 5, OPQ 6, JXX 7, CALL 8, RET 9, PUSHQ A, POPQ B.
- Register constants: RSP = 4, RNONE = F.
- Stat codes: AOK 1, HLT 2, ADR 3, INS 4.
- `srcA`:
  - `D_rA` for {2, 4, 6, A}.
  - RSP for {9, B}.
  - Otherwise F.
- `srcB`:
  - `D_rB` for {4, 5, 6}.
  - RSP for {8, 9, A, B}.
  - Otherwise F.
- `dstE`:
  - `D_rB` for {2, 3, 6}.
  - RSP for {8, 9, A, B}.
  - Otherwise F.
  - The CMOV condition is applied in execute, not here.
- `dstM`: `D_rA` for {5, B}; otherwise F.
- `valA` select, first match wins:
  1. `D_valP` if icode is CALL or JXX.
  2. Forwarding, only when `srcA != F`, checked in order: `e_dstE`→`e_valE`, `M_dstM`→`m_valM`, `M_dstE`→`M_valE`, `W_dstM`→`W_valM`, `W_dstE`→`W_valE`.
  3. Otherwise `rvalA`.
- `valB`: same forwarding order keyed on `srcB`, with no `valP` term; otherwise `rvalB`.
- Bubble value, D register: stat = 1, icode = 1, ifun = 0, rA = rB = F, valC = valP = 0.
- Bubble value, E register: stat = 1, icode = 1, ifun = 0, all dst/src = F, all vals = 0.

## Timing
- Reset: on a rising edge with `rst_n = 0`, both registers load their bubble values.
  - This overrides stall and bubble.
  - After that edge, all `E_*` outputs equal their bubble values, and `srcA = srcB = F`.
- D register update at each rising edge, when not in reset:
  - `D_stall = 1`: hold. Stall wins if `D_bubble` is also asserted.
  - Else `D_bubble = 1`: load bubble.
  - Else: load the `f_*` inputs.
- E register update at each rising edge:
  - `E_bubble = 1`: load bubble.
  - Else: load decode results (D stat/icode/ifun/valC, selected valA/valB, dstE/dstM/srcA/srcB).
  - `D_stall` does not affect the E register. A stalled D therefore re-issues the same decode into E unless `E_bubble` is set.
- Latency:
  - An instruction presented on `f_*` at edge N appears on `E_*` after edge N+1.
  - `srcA`/`srcB` are valid combinationally within the cycle after edge N.
- Forwarding and register-file reads are combinational within one cycle; there is no internal write-back.
- No byte or width truncation: all vals are W bits and pass through unmodified.
- Invalid icode (C–F): stat passes through as loaded; src/dst = F.

## Test plan
- Reset with `D_stall = 1` and `f_icode = 6`: hold `rst_n = 0` for 2 edges → `E_icode = 1`, `E_stat = 1`, `E_dstE = F`, `E_valA = 0`, `srcA = F`.
- `OPQ` rA = 2, rB = 3, `rvalA = 5`, `rvalB = 7`, no forwards → `srcA = 2`, `srcB = 3`, and after 2 edges `E_valA = 5`, `E_valB = 7`, `E_dstE = 3`, `E_dstM = F`.
- Forward priority: `srcA = 2` with `e_dstE = M_dstE = W_dstM = 2` (vals `0x11`, `0x22`, `0x33`) → `E_valA = 0x11`. Drop `e_dstE` to F → `E_valA = 0x22`. Set `srcA = F`, all dst = F → `E_valA = rvalA = 0`.
- `CALL` with `valP = 0x100` and `e_dstE = 4` → `E_valA = 0x100`, `srcB = 4`, `dstE = 4`. `POPQ` rA = 6 → `srcA = srcB = 4`, `E_dstE = 4`, `E_dstM = 6`.
- Stall/bubble:
  - `D_stall = 1` for 2 cycles with changing `f_*` → `srcA`/`srcB` constant, E reloads the same instruction each edge.
  - `D_stall = D_bubble = 1` → D holds.
  - `E_bubble = 1` → next `E_icode = 1`, `E_dstE = F`.
- `MRMOVQ` rA = 1, rB = 5, `valC = 0x8` → `srcB = 5`, `srcA = F`, `E_dstM = 1`, `E_valC = 0x8`.
